// File: rtl/if_id_skid_stage.sv
// -----------------------------------------------------------------------------
// if_id_skid_stage
//   IF->ID pipeline boundary for a multi-issue front end. Each beat carries
//   LANES (pc, inst) pairs plus a per-lane valid mask, moved with a
//   valid/ready handshake. Two beat slots (head + skid) let in_ready come
//   from registered state only, so there is no combinational path from
//   out_ready, stall or flush to in_ready. Stall freezes the stored beats.
//   Flush empties the stage. An empty stage drives all-zero payload as the
//   bubble.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active-low
//   flush         synchronous flush, active-high; beats are dropped next cycle
//   stall         blocks output transfer; stored beats are held
//   in_valid      upstream beat valid
//   in_ready      stage can accept a beat (fewer than two beats held)
//   in_lane_vld   per-lane valid mask of the input beat
//   in_pc         input pcs, lane i at [i*DATA_W +: DATA_W]
//   in_inst       input instructions, same packing as in_pc
//   out_valid     head beat valid
//   out_ready     downstream accepts the head beat
//   out_lane_vld  lane mask of the head beat
//   out_pc        head pcs
//   out_inst      head instructions
//   occupancy     number of beats held (0..2)
// -----------------------------------------------------------------------------
module if_id_skid_stage #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      stall,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_lane_vld,
  input  logic [LANES*DATA_W-1:0]   in_pc,
  input  logic [LANES*DATA_W-1:0]   in_inst,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_lane_vld,
  output logic [LANES*DATA_W-1:0]   out_pc,
  output logic [LANES*DATA_W-1:0]   out_inst,
  output logic [1:0]                occupancy
);

  localparam int W = LANES * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LANES-1:0] head_mask_q, head_mask_d, skid_mask_q, skid_mask_d;
  logic [W-1:0]     head_pc_q,   head_pc_d,   skid_pc_q,   skid_pc_d;
  logic [W-1:0]     head_inst_q, head_inst_d, skid_inst_q, skid_inst_d;

  logic [W-1:0]     cap_pc, cap_inst;
  logic             push, pop;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & ~stall;

  // Invalid lanes are captured as zero so downstream never sees stale words.
  always_comb begin
    cap_pc   = '0;
    cap_inst = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (in_lane_vld[i]) begin
        cap_pc[i*DATA_W +: DATA_W]   = in_pc[i*DATA_W +: DATA_W];
        cap_inst[i*DATA_W +: DATA_W] = in_inst[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    head_mask_d = head_mask_q;
    head_pc_d   = head_pc_q;
    head_inst_d = head_inst_q;
    skid_mask_d = skid_mask_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    if (flush) begin
      state_d     = EMPTY;
      head_mask_d = '0;
      head_pc_d   = '0;
      head_inst_d = '0;
      skid_mask_d = '0;
      skid_pc_d   = '0;
      skid_inst_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            head_mask_d = in_lane_vld;
            head_pc_d   = cap_pc;
            head_inst_d = cap_inst;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_mask_d = in_lane_vld;
            head_pc_d   = cap_pc;
            head_inst_d = cap_inst;
          end else if (push) begin
            state_d     = FULL;
            skid_mask_d = in_lane_vld;
            skid_pc_d   = cap_pc;
            skid_inst_d = cap_inst;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state_d     = ONE;
            head_mask_d = skid_mask_q;
            head_pc_d   = skid_pc_q;
            head_inst_d = skid_inst_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      head_mask_q <= '0;
      head_pc_q   <= '0;
      head_inst_q <= '0;
      skid_mask_q <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      head_mask_q <= head_mask_d;
      head_pc_q   <= head_pc_d;
      head_inst_q <= head_inst_d;
      skid_mask_q <= skid_mask_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  // Head registers keep their last contents after a pop; gate to the bubble.
  assign out_lane_vld = out_valid ? head_mask_q : '0;
  assign out_pc       = out_valid ? head_pc_q   : '0;
  assign out_inst     = out_valid ? head_inst_q : '0;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_skid_stage
//   Directed bench for if_id_skid_stage (DATA_W=32, LANES=2). Inputs change
//   1 ns after a rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_if_id_skid_stage;

  localparam int DATA_W = 32;
  localparam int LANES  = 2;
  localparam int W      = LANES * DATA_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             stall;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_lane_vld;
  logic [W-1:0]     in_pc;
  logic [W-1:0]     in_inst;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_lane_vld;
  logic [W-1:0]     out_pc;
  logic [W-1:0]     out_inst;
  logic [1:0]       occupancy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  if_id_skid_stage #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .stall        (stall),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_lane_vld  (in_lane_vld),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane_vld (out_lane_vld),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [LANES-1:0] m,
                       input logic [W-1:0] pc, input logic [W-1:0] inst);
    in_valid    = v;
    in_lane_vld = m;
    in_pc       = pc;
    in_inst     = inst;
  endtask

  task automatic chk_head(input string tag, input logic [LANES-1:0] m,
                          input logic [W-1:0] pc, input logic [W-1:0] inst);
    chk({tag, "_valid"}, W'(out_valid), W'(1'b1));
    chk({tag, "_mask"},  W'(out_lane_vld), W'(m));
    chk({tag, "_pc"},    out_pc, pc);
    chk({tag, "_inst"},  out_inst, inst);
  endtask

  localparam logic [W-1:0] PC_A = {32'h0000_1004, 32'h0000_1000};
  localparam logic [W-1:0] IN_A = {32'hAAAA_0001, 32'hAAAA_0000};
  localparam logic [W-1:0] PC_B = {32'h0000_2004, 32'h0000_2000};
  localparam logic [W-1:0] IN_B = {32'hBBBB_0001, 32'hBBBB_0000};
  localparam logic [W-1:0] PC_C = {32'h0000_3004, 32'h0000_3000};
  localparam logic [W-1:0] IN_C = {32'hCCCC_0001, 32'hCCCC_0000};
  localparam logic [W-1:0] PC_D = {32'h0000_4004, 32'h0000_4000};
  localparam logic [W-1:0] IN_D = {32'hDDDD_0001, 32'hDDDD_0000};
  localparam logic [W-1:0] PC_E = {32'h0000_5004, 32'h0000_5000};
  localparam logic [W-1:0] IN_E = {32'hEEEE_0001, 32'hEEEE_0000};

  initial begin
    // T1: reset with random inputs
    rst       = 1'b0;
    flush     = 1'b0;
    stall     = 1'b0;
    out_ready = 1'($urandom);
    drive(1'b1, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    #3;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready",  W'(in_ready),  W'(1'b1));
    chk("rst_occ",       W'(occupancy), '0);
    chk("rst_mask",      W'(out_lane_vld), '0);
    chk("rst_pc",        out_pc, '0);
    chk("rst_inst",      out_inst, '0);
    step();
    chk("rst_hold_occ",  W'(occupancy), '0);
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b0;
    rst = 1'b1;

    // T2: single beat
    out_ready = 1'b1;
    drive(1'b1, 2'b11, {32'h0000_0104, 32'h0000_0100}, {32'h00B5_0533, 32'h00A0_0093});
    step();
    drive(1'b0, '0, '0, '0);
    chk_head("t2", 2'b11, {32'h0000_0104, 32'h0000_0100}, {32'h00B5_0533, 32'h00A0_0093});
    chk("t2_occ1", W'(occupancy), W'(2'd1));
    step();
    chk("t2_occ0",   W'(occupancy), '0);
    chk("t2_empty",  W'(out_valid), '0);
    chk("t2_bubble", out_pc, '0);

    // T3: backpressure, A B C back-to-back
    out_ready = 1'b0;
    drive(1'b1, 2'b11, PC_A, IN_A);
    step();
    chk("t3_occ_a", W'(occupancy), W'(2'd1));
    drive(1'b1, 2'b11, PC_B, IN_B);
    step();
    chk("t3_occ_b",   W'(occupancy), W'(2'd2));
    chk("t3_rdy_low", W'(in_ready), '0);
    drive(1'b1, 2'b11, PC_C, IN_C);
    step();
    chk("t3_c_held_occ", W'(occupancy), W'(2'd2));
    chk_head("t3_a", 2'b11, PC_A, IN_A);
    out_ready = 1'b1;
    step();
    chk_head("t3_b", 2'b11, PC_B, IN_B);
    chk("t3_occ_after_a", W'(occupancy), W'(2'd1));
    step();
    drive(1'b0, '0, '0, '0);
    chk_head("t3_c", 2'b11, PC_C, IN_C);
    chk("t3_occ_c", W'(occupancy), W'(2'd1));
    step();
    chk("t3_drained", W'(out_valid), '0);

    // T4: stall hold
    out_ready = 1'b0;
    drive(1'b1, 2'b11, PC_A, IN_A);
    step();
    drive(1'b0, '0, '0, '0);
    stall     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_hold_pc",   out_pc, PC_A);
      chk("t4_hold_inst", out_inst, IN_A);
      chk("t4_hold_occ",  W'(occupancy), W'(2'd1));
    end
    stall = 1'b0;
    step();
    chk("t4_popped", W'(occupancy), '0);

    // T5: flush with two beats held and a beat presented
    out_ready = 1'b0;
    drive(1'b1, 2'b11, PC_A, IN_A);
    step();
    drive(1'b1, 2'b11, PC_B, IN_B);
    step();
    chk("t5_full", W'(occupancy), W'(2'd2));
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 2'b11, PC_D, IN_D);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("t5_occ",   W'(occupancy), '0);
    chk("t5_valid", W'(out_valid), '0);
    chk("t5_pc",    out_pc, '0);
    chk("t5_inst",  out_inst, '0);
    chk("t5_rdy",   W'(in_ready), W'(1'b1));
    step();
    chk("t5_d_absent", W'(out_valid), '0);

    // T6: lane mask zeroes invalid lane
    out_ready = 1'b0;
    drive(1'b1, 2'b01, {32'h0000_0200, 32'h0000_0300}, {32'hFFFF_FFFF, 32'h0000_0013});
    step();
    chk_head("t6", 2'b01, {32'h0, 32'h0000_0300}, {32'h0, 32'h0000_0013});

    // Push accepted during stall; head untouched
    stall     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 2'b10, PC_E, IN_E);
    step();
    drive(1'b0, '0, '0, '0);
    chk("stall_push_occ", W'(occupancy), W'(2'd2));
    chk("stall_push_head", out_pc, {32'h0, 32'h0000_0300});
    stall = 1'b0;
    step();
    chk_head("stall_e", 2'b10, {32'h0000_5004, 32'h0}, {32'hEEEE_0001, 32'h0});

    // Async reset mid-operation, then push on first edge after release
    #2;
    rst = 1'b0;
    #1;
    chk("arst_occ",   W'(occupancy), '0);
    chk("arst_valid", W'(out_valid), '0);
    out_ready = 1'b0;
    drive(1'b1, 2'b11, PC_C, IN_C);
    #2;
    rst = 1'b1;
    step();
    drive(1'b0, '0, '0, '0);
    chk_head("arst_first", 2'b11, PC_C, IN_C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
